// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: state encodings, default widths
// and the command FIFO entry layout helper.
package alu_issue_stage_pkg;

  localparam int ALU_WIDTH = 64;
  localparam int ALU_OPW   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } issue_state_e;

  // Entry layout is {a, b, op, acc_a}
  function automatic int cmd_entry_width(input int width, input int opw);
    return 2 * width + opw + 1;
  endfunction

endpackage

// File: rtl/alu_issue_stage_cmd_fifo.sv
// Command FIFO for the ALU issue stage: parameterised width/depth with an
// extra count bit so full and empty are distinguishable.
module alu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_s;
  logic          pop_s;

  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign full   = (count_r == (AW+1)'(DEPTH));
  assign empty  = (count_r == {(AW+1){1'b0}});
  assign count  = count_r;
  assign dout   = mem_r[rd_ptr_r];

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/collect stage in front of the ALU: queues commands, drives the ALU
// operands from registers and captures its result behind a valid/ready port.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OPW-1:0]   cmd_op,
  input  logic             cmd_acc_a,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic [WIDTH-1:0] acc,
  output logic             busy
);

  localparam int EW = cmd_entry_width(WIDTH, OPW);
  localparam int CW = $clog2(DEPTH) + 1;

  issue_state_e     state_r;
  issue_state_e     state_s;
  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CW-1:0]    fifo_count_s;
  logic [EW-1:0]    head_s;
  logic [WIDTH-1:0] head_a_s;
  logic [WIDTH-1:0] head_b_s;
  logic [OPW-1:0]   head_op_s;
  logic             head_acc_a_s;
  logic             capture_s;
  logic             release_s;

  assign cmd_ready    = !fifo_full_s;
  assign fifo_push_s  = cmd_valid && !fifo_full_s;
  assign busy         = (state_r != IDLE) || (fifo_count_s != {CW{1'b0}});

  assign head_a_s     = head_s[EW-1 -: WIDTH];
  assign head_b_s     = head_s[OPW+1 +: WIDTH];
  assign head_op_s    = head_s[1 +: OPW];
  assign head_acc_a_s = head_s[0];

  alu_cmd_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   ({cmd_a, cmd_b, cmd_op, cmd_acc_a}),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state plus pop/capture/release strobes
  always_comb begin
    state_s    = state_r;
    fifo_pop_s = 1'b0;
    capture_s  = 1'b0;
    release_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          state_s    = EXEC;
        end else begin
          state_s    = IDLE;
        end
      end
      EXEC: begin
        capture_s = 1'b1;
        state_s   = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          release_s = 1'b1;
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            state_s    = EXEC;
          end else begin
            state_s    = IDLE;
          end
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Operand load on pop, result/accumulator capture at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= {WIDTH{1'b0}};
      alu_b       <= {WIDTH{1'b0}};
      alu_control <= {OPW{1'b0}};
      res_valid   <= 1'b0;
      res_data    <= {WIDTH{1'b0}};
      res_carry   <= 1'b0;
      acc         <= {WIDTH{1'b0}};
    end else begin
      if (fifo_pop_s) begin
        alu_a       <= head_acc_a_s ? acc : head_a_s;
        alu_b       <= head_b_s;
        alu_control <= head_op_s;
      end
      if (capture_s) begin
        res_data  <= alu_out;
        res_carry <= alu_carry;
        acc       <= alu_out;
        res_valid <= 1'b1;
      end else if (release_s) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
